// File: rtl/serial_subtractor_pkg.sv
// Shared types and constants for the bit-serial subtractor.
// The FSM state encoding and the default operand width are defined here.
package serial_subtractor_pkg;

   localparam int WIDTH_DEFAULT = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: d = a - b - bin, bout set when the bit needs a borrow.
// Purely combinational; the serial datapath registers the borrow between bits.
module full_subtractor (
   input  logic a,
   input  logic b,
   input  logic bin,
   output logic d,
   output logic bout
);

   always_comb begin
      d    = a ^ b ^ bin;
      bout = (~a & b) | (~(a ^ b) & bin);
   end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor, LSB first, one bit per clock.
// Optional embedded assertions/covers are enabled by SERIAL_SUBTRACTOR_FORMAL_EN.
//
// state | meaning
// IDLE  | waiting for start; operands latched on acceptance
// RUN   | one bit of a - b processed per cycle, busy high
// DONE  | result registered, done pulses for one cycle
module serial_subtractor
   import serial_subtractor_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEFAULT
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             borrow
);

   localparam int IDX_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] d_sr;
   logic [IDX_W-1:0] idx;
   logic             br;
   logic             bit_a;
   logic             bit_b;
   logic             bit_d;
   logic             bit_bout;
   logic             last_bit;
   logic             accept;

   assign bit_a    = a_q[idx];
   assign bit_b    = b_q[idx];
   assign last_bit = (idx == IDX_LAST);

   full_subtractor u_full_subtractor (
      .a    (bit_a),
      .b    (bit_b),
      .bin  (br),
      .d    (bit_d),
      .bout (bit_bout)
   );

   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      done      = 1'b0;
      accept    = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               accept    = 1'b1;
               state_nxt = RUN;
            end
         end
         RUN: begin
            busy = 1'b1;
            if (last_bit) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state  <= IDLE;
         a_q    <= '0;
         b_q    <= '0;
         d_sr   <= '0;
         idx    <= '0;
         br     <= 1'b0;
         diff   <= '0;
         borrow <= 1'b0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            a_q <= a;
            b_q <= b;
            br  <= 1'b0;
            idx <= '0;
         end else if (state == RUN) begin
            br   <= bit_bout;
            d_sr <= {bit_d, d_sr[WIDTH-1:1]};
            idx  <= last_bit ? '0 : idx + 1'b1;
            // Final bit goes straight into the output so diff changes only on entry to DONE.
            if (last_bit) begin
               diff   <= {bit_d, d_sr[WIDTH-1:1]};
               borrow <= bit_bout;
            end
         end
      end
   end

`ifdef SERIAL_SUBTRACTOR_FORMAL_EN
   a_reset_quiet: assert property (@(posedge clk)
      !rstn |-> (diff == '0 && !borrow && !done && !busy));

   a_result: assert property (@(posedge clk) disable iff (!rstn)
      done |-> (diff == WIDTH'(a_q - b_q) && borrow == (a_q < b_q)));

   a_done_busy_excl: assert property (@(posedge clk) disable iff (!rstn)
      !(done && busy));

   a_done_single: assert property (@(posedge clk) disable iff (!rstn)
      done |=> !done);

   c_borrow_set:   cover property (@(posedge clk) disable iff (!rstn) done && borrow);
   c_borrow_clr:   cover property (@(posedge clk) disable iff (!rstn) done && !borrow);
   c_diff_zero:    cover property (@(posedge clk) disable iff (!rstn) done && diff == '0);
   c_start_ignore: cover property (@(posedge clk) disable iff (!rstn) busy && start);
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor at WIDTH=8.
module tb_serial_subtractor;

   localparam int WIDTH = 8;

   logic             clk;
   logic             rstn;
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] diff;
   logic             borrow;

   int n_asserts;
   int n_fail;

   serial_subtractor #(.WIDTH(WIDTH)) dut (
      .clk    (clk),
      .rstn   (rstn),
      .start  (start),
      .a      (a),
      .b      (b),
      .busy   (busy),
      .done   (done),
      .diff   (diff),
      .borrow (borrow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_asserts++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Pulse start for one cycle, then count busy cycles until done appears.
   task automatic run_op(input string tag, input logic [7:0] av, input logic [7:0] bv,
                         input logic [7:0] exp_diff, input logic exp_borrow,
                         input logic [7:0] prev_diff);
      int nbusy;
      int guard;
      @(negedge clk);
      a = av; b = bv; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      a = ~av; b = ~bv;
      check({tag, "_diff_hold"}, 32'(diff), 32'(prev_diff));
      nbusy = 0;
      guard = 0;
      while (busy && guard < 20) begin
         nbusy++;
         guard++;
         @(negedge clk);
      end
      check({tag, "_busy_cycles"}, nbusy, 8);
      check({tag, "_done"}, 32'(done), 1);
      check({tag, "_diff"}, 32'(diff), 32'(exp_diff));
      check({tag, "_borrow"}, 32'(borrow), 32'(exp_borrow));
      @(negedge clk);
      check({tag, "_done_one_cycle"}, 32'(done), 0);
      check({tag, "_diff_held"}, 32'(diff), 32'(exp_diff));
   endtask

   initial begin
      int nbusy;
      int ndone;
      int guard;
      int t_done [3];
      logic [7:0] d_at [3];

      n_asserts = 0;
      n_fail    = 0;
      rstn  = 1'b0;
      start = 1'b0;
      a     = '0;
      b     = '0;

      repeat (3) @(negedge clk);
      check("rst_busy", 32'(busy), 0);
      check("rst_done", 32'(done), 0);
      check("rst_diff", 32'(diff), 0);
      check("rst_borrow", 32'(borrow), 0);
      rstn = 1'b1;
      @(negedge clk);

      run_op("op200_55", 8'd200, 8'd55, 8'd145, 1'b0, 8'd0);
      run_op("op5_10",   8'd5,   8'd10, 8'hFB,  1'b1, 8'd145);
      run_op("op0_1",    8'd0,   8'd1,  8'hFF,  1'b1, 8'hFB);
      run_op("opFF_FF",  8'hFF,  8'hFF, 8'd0,   1'b0, 8'hFF);

      // Start during RUN must be ignored.
      @(negedge clk);
      a = 8'd9; b = 8'd3; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      nbusy = 0;
      ndone = 0;
      guard = 0;
      while (guard < 40) begin
         if (busy) nbusy++;
         if (done) begin
            ndone++;
            check("ign_diff", 32'(diff), 6);
            check("ign_borrow", 32'(borrow), 0);
         end
         if (busy && nbusy == 3) begin
            a = 8'd1; b = 8'd2; start = 1'b1;
         end else begin
            start = 1'b0;
         end
         guard++;
         @(negedge clk);
      end
      check("ign_busy_total", nbusy, 8);
      check("ign_done_count", ndone, 1);

      // Reset in the middle of an operation.
      @(negedge clk);
      a = 8'd50; b = 8'd20; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      check("abort_busy_before", 32'(busy), 1);
      rstn = 1'b0;
      #1;
      check("abort_busy", 32'(busy), 0);
      check("abort_diff", 32'(diff), 0);
      check("abort_borrow", 32'(borrow), 0);
      ndone = 0;
      nbusy = 0;
      repeat (3) begin
         @(negedge clk);
         if (done) ndone++;
      end
      rstn = 1'b1;
      repeat (12) begin
         @(negedge clk);
         if (done) ndone++;
         if (busy) nbusy++;
      end
      check("abort_no_done", ndone, 0);
      check("abort_stays_idle", nbusy, 0);
      run_op("op7_7", 8'd7, 8'd7, 8'd0, 1'b0, 8'd0);

      // Start held high: back-to-back operations.
      @(negedge clk);
      a = 8'd100; b = 8'd1; start = 1'b1;
      ndone = 0;
      guard = 0;
      while (ndone < 3 && guard < 60) begin
         @(negedge clk);
         guard++;
         if (done) begin
            t_done[ndone] = guard;
            d_at[ndone]   = diff;
            ndone++;
         end
      end
      start = 1'b0;
      check("b2b_done_count", ndone, 3);
      if (ndone == 3) begin
         check("b2b_diff0", 32'(d_at[0]), 99);
         check("b2b_diff1", 32'(d_at[1]), 99);
         check("b2b_diff2", 32'(d_at[2]), 99);
         check("b2b_gap01", t_done[1] - t_done[0], 10);
         check("b2b_gap12", t_done[2] - t_done[1], 10);
      end
      repeat (12) @(negedge clk);
      check("final_idle", 32'(busy), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

endmodule
